escalonador_tiros: RTL and testbench
====================================

// Module: escalonador_tiros
// PURPOSE
// - Fleet fire scheduler. It decides which living enemy fires next and when, then grants it one of a fixed pool of enemy-bullet slots.
// - Sits beside the fleet, which instantiates one row module per enemy row. Fire grants go to the enemy/row logic.
// - Slot releases come back from the bullet logic when a bullet hits something or leaves the screen.
// PARAMETERS
// N_INIMIGOS  20           number of enemies (index = row*5 + column); 2 <= N <= 32
// N_SLOTS     4            maximum enemy bullets in flight
// COOLDOWN    25_000_000   CLOCK_50 cycles between fire attempts (0.5 s)
// LFSR_SEED   16'hACE1     LFSR reset value; must be nonzero
// PORTS
// CLOCK_50       in   1            system clock, 50 MHz
// reset          in   1            asynchronous reset, active-low
// pausa          in   1            1 = freeze scheduling
// reiniciarJogo  in   1            synchronous restart, 1-cycle pulse
// vivo           in   N_INIMIGOS   alive mask; bit i = enemy i alive
// liberar        in   N_SLOTS      slot release pulses; bit k = bullet k finished
// disparo        out  N_INIMIGOS   one-hot 1-cycle fire grant to enemy i
// disparo_slot   out  clog2(N_SLOTS)  slot assigned; valid while disparo != 0
// slot_ocupado   out  N_SLOTS      busy mask of the bullet slots
// n_ocupados     out  clog2(N_SLOTS+1)  popcount of slot_ocupado
// sem_alvos      out  1            1 = last search found no living enemy
// BEHAVIOUR
// - Reset (reset=0, async): all outputs 0, state OCIOSO, cooldown counter = COOLDOWN, LFSR = LFSR_SEED.
// - reiniciarJogo: same values as reset, applied at the clock edge. It has priority over every other input.
// - The LFSR is 16-bit Galois, taps 0xB400. It advances every cycle, except while pausa=1.
// - FSM states:
//   OCIOSO: count down while pausa=0. At 0 with a free slot, go to SORTEIO. At 0 with no free slot, hold at 0 and wait.
//   SORTEIO: cand = lfsr[k-1:0] with k = clog2(N). If cand >= N, cand -= N (one subtract suffices). Set scan count = 0. Go to BUSCA.
//   BUSCA: test one index per cycle. If vivo[cand]=1, go to DISPARO. Otherwise cand = (cand+1) mod N and count++.
//     If count reaches N: set sem_alvos=1, reload COOLDOWN, go to OCIOSO.
//   DISPARO: re-check vivo[cand]. If 0, return to BUSCA with cand+1 (count keeps its value). If 1, do the following on the same edge:
//     assert disparo[cand] and disparo_slot = lowest free slot index, for exactly one cycle;
//     set that slot_ocupado bit; set sem_alvos=0; reload COOLDOWN; go to OCIOSO.
// - Latency: the grant appears 3 cycles after the counter hits 0, plus one cycle per dead enemy skipped.
// - Slot release: liberar[k] clears slot_ocupado[k] at the next edge.
//   Release of a slot that is already free is ignored.
//   Releases are processed while pausa=1 and in every FSM state.
// - Simultaneous grant and release: the grant picks a slot that was free at the start of the cycle. A slot released in that same cycle becomes free for the next grant only.
// - pausa=1: FSM, counter and LFSR hold; outputs hold, except disparo, which is forced to 0.
//   A grant that would fire during pausa is deferred until pausa returns to 0.
// - n_ocupados is registered and equals the popcount of slot_ocupado at all times.
// - At most one grant per cycle.
// - disparo is never asserted for an enemy whose vivo bit is 0 in the cycle of the grant.
// STRUCTURE
// - Package escalonador_pkg:
//   state encoding OCIOSO=0, SORTEIO=1, BUSCA=2, DISPARO=3;
//   widths W_IDX = clog2(N_INIMIGOS), W_SLOT = clog2(N_SLOTS);
//   LFSR tap constant 16'hB400.
// - Sub-module lfsr_16 holds the LFSR: ports CLOCK_50, reset, en, q[15:0], seed parameter.
// - The free-slot priority encoder and the popcount stay inline.
// TESTING
// Run the bench with COOLDOWN=8 and N_SLOTS=4.
// 1. vivo=all 1s, no liberar:
//    -> exactly 4 grants, spaced about 12 cycles apart, using slots 0, 1, 2, 3 in that order;
//    -> then no more grants, n_ocupados=4.
// 2. From the state of test 1, pulse liberar=4'b0100:
//    -> the next grant uses slot 2, about 4 cycles after the counter reaches 0.
// 3. vivo=20'h00001 and LFSR forced so that cand=5:
//    -> BUSCA wraps around, the grant goes to disparo[0], at latency 3 + 15 cycles.
// 4. vivo=0:
//    -> after N scan cycles sem_alvos=1 and disparo never asserts;
//    -> then set vivo bit 7: the next grant is disparo[7] and sem_alvos returns to 0.
// 5. Drop vivo[cand] in the cycle the FSM enters DISPARO:
//    -> no grant to that enemy; the FSM resumes BUSCA at cand+1.
// 6. Assert pausa mid-countdown for 50 cycles:
//    -> counter and LFSR frozen, and liberar still clears its slot;
//    -> reiniciarJogo and reset mid-BUSCA each return all outputs to 0 and the LFSR to LFSR_SEED.

Source files
------------

// File: rtl/escalonador_pkg.sv
// Shared definitions for the enemy fire scheduler.
// Holds the scheduler state encoding, the default fleet/slot sizes with
// their index widths, the LFSR feedback taps and the LFSR step and width
// helpers used by the scheduler and its LFSR sub-module.
package escalonador_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      SORTEIO = 2'd1,
      BUSCA   = 2'd2,
      DISPARO = 2'd3
   } estado_t;

   localparam int N_INIMIGOS_DEF = 20;
   localparam int N_SLOTS_DEF    = 4;
   localparam int W_IDX          = $clog2(N_INIMIGOS_DEF);
   localparam int W_SLOT         = $clog2(N_SLOTS_DEF);

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Galois right-shift step: the bit shifted out decides whether the taps are applied.
   function automatic logic [15:0] lfsr_passo(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/escalonador_tiros_lfsr.sv
// 16-bit Galois LFSR feeding the random enemy draw.
// Ports: CLOCK_50 clock, reset async active-low (loads SEED),
//        en advances one step per cycle, carga loads SEED synchronously
//        (wins over en), q current LFSR value.
module lfsr_16
   import escalonador_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        en,
   input  logic        carga,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (carga)
         q_d = SEED;
      else if (en)
         q_d = lfsr_passo(q_q);
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         q_q <= SEED;
      else
         q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/escalonador_tiros.sv
// Fleet fire scheduler: picks the next living enemy to fire and grants it
// one of N_SLOTS enemy-bullet slots.
// Ports: CLOCK_50 clock, reset async active-low, pausa freezes scheduling,
//        reiniciarJogo synchronous restart, vivo alive mask,
//        liberar slot release pulses, disparo one-hot grant,
//        disparo_slot slot given with the grant, slot_ocupado busy mask,
//        n_ocupados busy count, sem_alvos last search found nobody alive.
//
// state   | meaning
// OCIOSO  | cooldown countdown; at 0 waits for a free slot
// SORTEIO | draws the starting candidate from the LFSR
// BUSCA   | walks the fleet one index per cycle looking for a living enemy
// DISPARO | re-checks the candidate and grants the lowest free slot
module escalonador_tiros
   import escalonador_pkg::*;
#(
   parameter int          N_INIMIGOS = N_INIMIGOS_DEF,
   parameter int          N_SLOTS    = N_SLOTS_DEF,
   parameter int          COOLDOWN   = 25_000_000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         W_I = largura(N_INIMIGOS),
   localparam int         W_S = largura(N_SLOTS),
   localparam int         W_N = $clog2(N_SLOTS + 1)
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  pausa,
   input  logic                  reiniciarJogo,
   input  logic [N_INIMIGOS-1:0] vivo,
   input  logic [N_SLOTS-1:0]    liberar,
   output logic [N_INIMIGOS-1:0] disparo,
   output logic [W_S-1:0]        disparo_slot,
   output logic [N_SLOTS-1:0]    slot_ocupado,
   output logic [W_N-1:0]        n_ocupados,
   output logic                  sem_alvos
);

   localparam int                  W_C     = largura(COOLDOWN + 1);
   localparam logic [W_C-1:0]      RECARGA = W_C'(COOLDOWN);
   localparam logic [W_I-1:0]      ULTIMO  = W_I'(N_INIMIGOS - 1);
   localparam logic [W_I:0]        N_TOTAL = (W_I + 1)'(N_INIMIGOS);
   localparam logic [N_INIMIGOS-1:0] UM    = N_INIMIGOS'(1);

   estado_t             estado_q, estado_d;
   logic [W_C-1:0]      cnt_q, cnt_d;
   logic [W_I-1:0]      cand_q, cand_d;
   logic [W_I:0]        varridos_q, varridos_d;
   logic [N_SLOTS-1:0]  slot_ocupado_q, slot_ocupado_d;
   logic [W_N-1:0]      n_ocupados_q, n_ocupados_d;
   logic                sem_alvos_q, sem_alvos_d;

   logic [15:0]         lfsr;
   logic                lfsr_unused;
   logic [W_I-1:0]      sorteio;
   logic [W_I-1:0]      cand_inc;
   logic [W_I:0]        varridos_inc;
   logic                livre_existe;
   logic [W_S-1:0]      livre_idx;
   logic                conceder;

   lfsr_16 #(.SEED(LFSR_SEED)) u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .en       (!pausa),
      .carga    (reiniciarJogo),
      .q        (lfsr)
   );

   assign lfsr_unused = ^lfsr;

   // Low LFSR bits range up to 2*N-1 at most, so one conditional subtract folds them into range.
   assign sorteio      = ({1'b0, lfsr[W_I-1:0]} >= N_TOTAL) ? lfsr[W_I-1:0] - W_I'(N_INIMIGOS)
                                                             : lfsr[W_I-1:0];
   assign cand_inc     = (cand_q == ULTIMO) ? '0 : cand_q + 1'b1;
   assign varridos_inc = varridos_q + 1'b1;

   // Lowest free slot, judged on the busy mask at the start of the cycle so a
   // same-cycle release only helps the following grant.
   always_comb begin
      livre_existe = 1'b0;
      livre_idx    = '0;
      for (int k = N_SLOTS - 1; k >= 0; k--) begin
         if (!slot_ocupado_q[k]) begin
            livre_existe = 1'b1;
            livre_idx    = W_S'(k);
         end
      end
   end

   assign conceder = (estado_q == DISPARO) && vivo[cand_q] && !pausa && !reiniciarJogo
                     && livre_existe;

   always_comb begin
      estado_d       = estado_q;
      cnt_d          = cnt_q;
      cand_d         = cand_q;
      varridos_d     = varridos_q;
      sem_alvos_d    = sem_alvos_q;
      slot_ocupado_d = slot_ocupado_q & ~liberar;
      n_ocupados_d   = '0;

      if (conceder)
         slot_ocupado_d[livre_idx] = 1'b1;

      if (!pausa) begin
         case (estado_q)
            OCIOSO: begin
               if (cnt_q != '0)
                  cnt_d = cnt_q - 1'b1;
               else if (livre_existe)
                  estado_d = SORTEIO;
            end
            SORTEIO: begin
               cand_d     = sorteio;
               varridos_d = '0;
               estado_d   = BUSCA;
            end
            BUSCA: begin
               if (vivo[cand_q]) begin
                  estado_d = DISPARO;
               end else begin
                  cand_d     = cand_inc;
                  varridos_d = varridos_inc;
                  if (varridos_inc == N_TOTAL) begin
                     sem_alvos_d = 1'b1;
                     cnt_d       = RECARGA;
                     estado_d    = OCIOSO;
                  end
               end
            end
            DISPARO: begin
               if (conceder) begin
                  sem_alvos_d = 1'b0;
                  cnt_d       = RECARGA;
                  estado_d    = OCIOSO;
               end else if (!vivo[cand_q]) begin
                  // Candidate died between search and grant: keep walking, scan count untouched.
                  cand_d   = cand_inc;
                  estado_d = BUSCA;
               end
            end
            default: estado_d = OCIOSO;
         endcase
      end

      if (reiniciarJogo) begin
         estado_d       = OCIOSO;
         cnt_d          = RECARGA;
         cand_d         = '0;
         varridos_d     = '0;
         sem_alvos_d    = 1'b0;
         slot_ocupado_d = '0;
      end

      for (int k = 0; k < N_SLOTS; k++)
         n_ocupados_d = n_ocupados_d + W_N'(slot_ocupado_d[k]);
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         estado_q       <= OCIOSO;
         cnt_q          <= RECARGA;
         cand_q         <= '0;
         varridos_q     <= '0;
         sem_alvos_q    <= 1'b0;
         slot_ocupado_q <= '0;
         n_ocupados_q   <= '0;
      end else begin
         estado_q       <= estado_d;
         cnt_q          <= cnt_d;
         cand_q         <= cand_d;
         varridos_q     <= varridos_d;
         sem_alvos_q    <= sem_alvos_d;
         slot_ocupado_q <= slot_ocupado_d;
         n_ocupados_q   <= n_ocupados_d;
      end
   end

   assign disparo      = conceder ? (UM << cand_q) : '0;
   assign disparo_slot = conceder ? livre_idx : '0;
   assign slot_ocupado = slot_ocupado_q;
   assign n_ocupados   = n_ocupados_q;
   assign sem_alvos    = sem_alvos_q;

endmodule

// File: tb/tb_escalonador_tiros.sv
// Self-checking bench for escalonador_tiros (N=20, 4 slots, cooldown 8).
// A behavioural reference model predicts every output each cycle; directed
// steps then check grant order, spacing, latency, wrap-around, empty fleet,
// candidate dying at grant time, pause, restart and async reset, followed by
// a randomized stretch.
module tb_escalonador_tiros;
   import escalonador_pkg::*;

   localparam int          N    = 20;
   localparam int          NS   = 4;
   localparam int          CD   = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   // reference model phases
   localparam int F_ESPERA   = 0;
   localparam int F_SORTEIO  = 1;
   localparam int F_BUSCA    = 2;
   localparam int F_CONFIRMA = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              pausa = 1'b0;
   logic              reinic = 1'b0;
   logic [N-1:0]      vivo = '0;
   logic [NS-1:0]     liberar = '0;
   logic [N-1:0]      disparo;
   logic [W_SLOT-1:0] disparo_slot;
   logic [NS-1:0]     slot_ocupado;
   logic [2:0]        n_ocupados;
   logic              sem_alvos;

   int testes = 0;
   int falhas = 0;

   logic [15:0]   m_lfsr;
   int            m_cnt, m_cand, m_scan, m_fase;
   logic [NS-1:0] m_slots;
   logic          m_sem;

   int cyc = 0;
   int g_cnt = 0, g_idx = -1, g_slot = -1, g_cyc = 0;

   always #5 clk = ~clk;

   escalonador_tiros #(
      .N_INIMIGOS (N),
      .N_SLOTS    (NS),
      .COOLDOWN   (CD),
      .LFSR_SEED  (SEED)
   ) dut (
      .CLOCK_50      (clk),
      .reset         (rst_n),
      .pausa         (pausa),
      .reiniciarJogo (reinic),
      .vivo          (vivo),
      .liberar       (liberar),
      .disparo       (disparo),
      .disparo_slot  (disparo_slot),
      .slot_ocupado  (slot_ocupado),
      .n_ocupados    (n_ocupados),
      .sem_alvos     (sem_alvos)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   function automatic int menor_livre(input logic [NS-1:0] s);
      for (int k = 0; k < NS; k++)
         if (!s[k]) return k;
      return 0;
   endfunction

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      testes++;
      assert (obs === esp) else begin
         falhas++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
      end
   endtask

   task automatic modelo_reset();
      m_lfsr  = SEED;
      m_cnt   = CD;
      m_fase  = F_ESPERA;
      m_cand  = 0;
      m_scan  = 0;
      m_slots = '0;
      m_sem   = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the inputs of the cycle just ended.
   task automatic modelo_passo();
      logic          g;
      logic [NS-1:0] antes;
      antes = m_slots;
      g = (m_fase == F_CONFIRMA) && vivo[m_cand] && !pausa && !reinic;
      if (reinic) begin
         modelo_reset();
         return;
      end
      m_slots = m_slots & ~liberar;
      if (g) begin
         m_slots[menor_livre(antes)] = 1'b1;
         m_sem  = 1'b0;
         m_cnt  = CD;
         m_fase = F_ESPERA;
      end else if (!pausa) begin
         case (m_fase)
            F_ESPERA: begin
               if (m_cnt > 0) m_cnt--;
               else if (antes != '1) m_fase = F_SORTEIO;
            end
            F_SORTEIO: begin
               m_cand = int'(m_lfsr[4:0]) % N;
               m_scan = 0;
               m_fase = F_BUSCA;
            end
            F_BUSCA: begin
               if (vivo[m_cand]) m_fase = F_CONFIRMA;
               else begin
                  m_cand = (m_cand + 1) % N;
                  m_scan++;
                  if (m_scan == N) begin
                     m_sem  = 1'b1;
                     m_cnt  = CD;
                     m_fase = F_ESPERA;
                  end
               end
            end
            default: begin
               if (!vivo[m_cand]) begin
                  m_cand = (m_cand + 1) % N;
                  m_fase = F_BUSCA;
               end
            end
         endcase
      end
      if (!pausa) m_lfsr = ref_lfsr(m_lfsr);
   endtask

   // Compare on the falling edge, then advance DUT and model through one rising edge.
   task automatic ciclo();
      logic         g;
      logic [N-1:0] um;
      logic [N-1:0] e_disp;
      int           e_slot;
      um = 1;
      @(negedge clk);
      g = rst_n && (m_fase == F_CONFIRMA) && vivo[m_cand] && !pausa && !reinic;
      e_disp = g ? (um << m_cand) : '0;
      e_slot = g ? menor_livre(m_slots) : 0;
      verifica("disparo", disparo, e_disp);
      verifica("disparo_slot", disparo_slot, e_slot);
      verifica("slot_ocupado", slot_ocupado, m_slots);
      verifica("n_ocupados", n_ocupados, $countones(m_slots));
      verifica("sem_alvos", sem_alvos, m_sem);
      verifica("lfsr", dut.u_lfsr.q, m_lfsr);
      if (disparo != '0) begin
         g_cnt++;
         g_slot = int'(disparo_slot);
         g_cyc  = cyc;
         for (int k = 0; k < N; k++)
            if (disparo[k]) g_idx = k;
      end
      @(posedge clk);
      if (!rst_n) modelo_reset();
      else modelo_passo();
      cyc++;
      #1;
   endtask

   task automatic ate_concessao(input int limite, input string tag);
      int g0;
      g0 = g_cnt;
      for (int i = 0; i < limite && g_cnt == g0; i++) ciclo();
      verifica({tag, " grant seen"}, (g_cnt != g0), 1);
   endtask

   task automatic ate_fase(input int f, input int limite, input string tag);
      for (int i = 0; i < limite && m_fase != f; i++) ciclo();
      verifica({tag, " phase reached"}, (m_fase == f), 1);
   endtask

   initial begin
      int prev, t, g0, c;
      logic [15:0] l0;
      logic achou;

      modelo_reset();
      vivo = '1;
      ciclo();
      ciclo();
      verifica("reset disparo", disparo, 0);
      verifica("reset slot_ocupado", slot_ocupado, 0);
      verifica("reset n_ocupados", n_ocupados, 0);
      verifica("reset sem_alvos", sem_alvos, 0);
      verifica("reset lfsr", dut.u_lfsr.q, SEED);
      rst_n = 1'b1;

      // 1: full fleet, four grants in slot order, 12 cycles apart, then saturation
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         ate_concessao(40, "t1");
         verifica("t1 slot", g_slot, k);
         if (k > 0) verifica("t1 spacing", g_cyc - prev, 12);
         prev = g_cyc;
      end
      g0 = g_cnt;
      repeat (40) ciclo();
      verifica("t1 no extra grant", g_cnt, g0);
      verifica("t1 n_ocupados", n_ocupados, 4);

      // 2: free slot 2 while the counter waits at zero
      liberar = 4'b0100;
      ciclo();
      liberar = '0;
      t = cyc;
      ate_concessao(20, "t2");
      verifica("t2 slot", g_slot, 2);
      verifica("t2 latency", g_cyc - t, 3);

      // 3: only enemy 0 alive, release timed so the draw lands on candidate 5
      vivo = 20'h00001;
      repeat (12) ciclo();
      achou = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (m_fase == F_ESPERA && m_cnt == 0 && m_slots == 4'hF &&
             (int'(ref_lfsr(ref_lfsr(m_lfsr)) & 16'h001F) % N) == 5) begin
            achou = 1'b1;
            break;
         end
         ciclo();
      end
      verifica("t3 draw alignment", achou, 1);
      liberar = 4'b1000;
      ciclo();
      liberar = '0;
      t = cyc;
      ate_concessao(60, "t3");
      verifica("t3 enemy", g_idx, 0);
      verifica("t3 slot", g_slot, 3);
      verifica("t3 latency", g_cyc - t, 18);

      // 4: empty fleet, then enemy 7 comes alive
      vivo = '0;
      repeat (12) ciclo();
      liberar = 4'b0010;
      ciclo();
      liberar = '0;
      t = cyc;
      g0 = g_cnt;
      for (int i = 0; i < 60; i++) begin
         if (sem_alvos === 1'b1) break;
         ciclo();
      end
      verifica("t4 sem_alvos", sem_alvos, 1);
      verifica("t4 scan length", cyc - t, 22);
      verifica("t4 no grant", g_cnt, g0);
      vivo = 20'h00080;
      ate_concessao(80, "t4b");
      verifica("t4 enemy", g_idx, 7);
      verifica("t4 slot", g_slot, 1);
      verifica("t4 sem_alvos cleared", sem_alvos, 0);

      // 5: candidate dies the cycle the grant stage is entered
      vivo = '1;
      liberar = 4'b0001;
      ciclo();
      liberar = '0;
      ate_fase(F_CONFIRMA, 60, "t5");
      c = m_cand;
      vivo[c] = 1'b0;
      ate_concessao(20, "t5");
      verifica("t5 enemy", g_idx, (c + 1) % N);
      verifica("t5 slot", g_slot, 0);
      vivo = '1;

      // 6: pause mid-countdown, release during pause, restart and reset mid-search
      repeat (3) ciclo();
      l0 = m_lfsr;
      pausa = 1'b1;
      for (int i = 0; i < 50; i++) begin
         liberar = (i == 10) ? 4'b0010 : 4'b0000;
         ciclo();
      end
      liberar = '0;
      verifica("t6 lfsr frozen", dut.u_lfsr.q, l0);
      verifica("t6 counter frozen", dut.cnt_q, 5);
      verifica("t6 release in pause", slot_ocupado, 4'b1101);
      verifica("t6 n_ocupados", n_ocupados, 3);
      pausa = 1'b0;
      ate_fase(F_BUSCA, 60, "t6 busca");
      reinic = 1'b1;
      ciclo();
      reinic = 1'b0;
      verifica("restart slot_ocupado", slot_ocupado, 0);
      verifica("restart n_ocupados", n_ocupados, 0);
      verifica("restart sem_alvos", sem_alvos, 0);
      verifica("restart lfsr", dut.u_lfsr.q, SEED);
      verifica("restart counter", dut.cnt_q, CD);
      ate_concessao(40, "t6c");
      ate_fase(F_BUSCA, 60, "t6 busca2");
      #2;
      rst_n = 1'b0;
      #1;
      modelo_reset();
      verifica("async reset disparo", disparo, 0);
      verifica("async reset slot_ocupado", slot_ocupado, 0);
      verifica("async reset n_ocupados", n_ocupados, 0);
      verifica("async reset lfsr", dut.u_lfsr.q, SEED);
      ciclo();
      ciclo();
      rst_n = 1'b1;
      ate_concessao(40, "after reset");
      verifica("after reset slot", g_slot, 0);

      // randomized traffic against the model
      vivo = '1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) vivo = N'($urandom) | N'($urandom);
         liberar = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
         pausa   = ($urandom_range(0, 11) == 0);
         reinic  = ($urandom_range(0, 149) == 0);
         ciclo();
      end
      liberar = '0;
      pausa   = 1'b0;
      reinic  = 1'b0;
      ciclo();

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
